// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ============================================================================
// lif_neuron_array_if : step, current, config and spike bundle for the array
// Rev 1.0
// ============================================================================
interface lif_neuron_array_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int c_IW = $clog2(N);

  logic            en;
  logic [N*W-1:0]  cur_in;
  logic            cfg_we;
  logic [2:0]      cfg_addr;
  logic [W-1:0]    cfg_data;
  logic [c_IW-1:0] idx;
  logic [N-1:0]    spike_out;
  logic            frame_done;
  logic [N-1:0]    spike_frame;

  modport master (
    output en, cur_in, cfg_we, cfg_addr, cfg_data,
    input  idx, spike_out, frame_done, spike_frame
  );

  modport slave (
    input  en, cur_in, cfg_we, cfg_addr, cfg_data,
    output idx, spike_out, frame_done, spike_frame
  );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// lif_neuron_array : round-robin time-multiplexed leaky integrate-and-fire array
// Rev 1.0
// ============================================================================
module lif_neuron_array #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RW = 3
) (
  input  logic              clk,
  input  logic              rst,
  lif_neuron_array_if.slave bus
);
  localparam int              c_IW   = $clog2(N);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

  logic [W-1:0]    r_v    [N];
  logic [RW-1:0]   r_refr [N];
  logic [c_IW-1:0] r_idx;
  logic [N-1:0]    r_spike_out;
  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_spike_frame;
  logic            r_frame_done;
  logic            r_inhibit;

  logic [W-1:0]    r_thresh;
  logic [2:0]      r_leak_shift;
  logic [RW-1:0]   r_refr_period;
  logic [W-1:0]    r_v_reset;
  logic [W-1:0]    r_inh_w;

  logic [W-1:0]    w_cur;
  logic [W-1:0]    w_v;
  logic [RW-1:0]   w_refr;
  logic [W-1:0]    w_vinh;
  logic [W-1:0]    w_vl;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_sat;
  logic            w_refractory;
  logic            w_fire;
  logic [N-1:0]    w_frame;

  always_comb begin
    w_cur  = '0;
    w_v    = '0;
    w_refr = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_cur  = bus.cur_in[i*W +: W];
        w_v    = r_v[i];
        w_refr = r_refr[i];
      end
    end
  end

  assign w_refractory = (w_refr != '0);
  assign w_vinh       = !r_inhibit ? w_v : ((w_v > r_inh_w) ? (w_v - r_inh_w) : '0);
  // A zero shift would subtract the whole potential, so it is treated as "no leak".
  assign w_vl         = (r_leak_shift == 3'd0) ? w_vinh : (w_vinh - (w_vinh >> r_leak_shift));
  assign w_sum        = {1'b0, w_vl} + {1'b0, w_cur};
  assign w_sat        = w_sum[W] ? '1 : w_sum[W-1:0];
  assign w_fire       = !w_refractory && (w_sat >= r_thresh);

  always_comb begin
    w_frame        = r_acc;
    w_frame[N-1]   = w_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_v[i]    <= '0;
        r_refr[i] <= '0;
      end
      r_idx         <= '0;
      r_spike_out   <= '0;
      r_acc         <= '0;
      r_spike_frame <= '0;
      r_frame_done  <= 1'b0;
      r_inhibit     <= 1'b0;
      r_thresh      <= {1'b1, {(W-1){1'b0}}};
      r_leak_shift  <= 3'd2;
      r_refr_period <= RW'(2);
      r_v_reset     <= '0;
      r_inh_w       <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.en) begin
        r_idx              <= r_idx + c_IW'(1);
        r_spike_out[r_idx] <= w_fire;
        r_acc[r_idx]       <= w_fire;
        if (w_refractory) begin
          r_refr[r_idx] <= w_refr - RW'(1);
          r_v[r_idx]    <= r_v_reset;
        end else if (w_fire) begin
          r_refr[r_idx] <= r_refr_period;
          r_v[r_idx]    <= r_v_reset;
        end else begin
          r_v[r_idx]    <= w_sat;
        end
        if (r_idx == c_LAST) begin
          r_spike_frame <= w_frame;
          r_frame_done  <= 1'b1;
          r_inhibit     <= |w_frame;
        end
      end
      // Config lands after this cycle's service, so a same-cycle service sees old values.
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          3'd0:    r_thresh      <= bus.cfg_data;
          3'd1:    r_leak_shift  <= bus.cfg_data[2:0];
          3'd2:    r_refr_period <= bus.cfg_data[RW-1:0];
          3'd3:    r_v_reset     <= bus.cfg_data;
          3'd4:    r_inh_w       <= bus.cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.idx         = r_idx;
  assign bus.spike_out   = r_spike_out;
  assign bus.frame_done  = r_frame_done;
  assign bus.spike_frame = r_spike_frame;
endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
// tb_lif_neuron_array : directed and randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_lif_neuron_array;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 3;
  localparam int VMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lif_neuron_array_if #(.N(N), .W(W)) bus ();

  lif_neuron_array #(.N(N), .W(W), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int         mv  [N];
  int         mr  [N];
  int         cur [N];
  int         midx;
  logic [N-1:0] mspk, macc, mframe;
  logic       mdone, minh;
  int         cthr, cls, crp, cvr, ciw;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mr[i] = 0; cur[i] = 0;
    end
    midx = 0; mspk = '0; macc = '0; mframe = '0; mdone = 1'b0; minh = 1'b0;
    cthr = 1 << (W - 1); cls = 2; crp = 2; cvr = 0; ciw = 0;
  endtask

  // Applies current inputs to the model, then advances one clock edge.
  task automatic tick();
    int   i, vp, vl, s;
    logic sp;
    for (int k = 0; k < N; k++) bus.cur_in[k*W +: W] = W'(cur[k]);
    mdone = 1'b0;
    if (bus.en) begin
      i  = midx;
      sp = 1'b0;
      if (mr[i] > 0) begin
        mr[i] = mr[i] - 1;
        mv[i] = cvr;
      end else begin
        vp = mv[i];
        if (minh) vp = (vp > ciw) ? vp - ciw : 0;
        vl = (cls == 0) ? vp : vp - vp / (2 ** cls);
        s  = vl + cur[i];
        if (s > VMAX) s = VMAX;
        if (s >= cthr) begin
          sp = 1'b1; mv[i] = cvr; mr[i] = crp;
        end else begin
          mv[i] = s;
        end
      end
      mspk[i] = sp;
      macc[i] = sp;
      if (i == N - 1) begin
        mframe = macc; mdone = 1'b1; minh = |macc;
      end
      midx = (midx + 1) % N;
    end
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        3'd0: cthr = int'(bus.cfg_data);
        3'd1: cls  = int'(bus.cfg_data) % 8;
        3'd2: crp  = int'(bus.cfg_data) % (1 << RW);
        3'd3: cvr  = int'(bus.cfg_data);
        3'd4: ciw  = int'(bus.cfg_data);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [2:0] a, input logic [W-1:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    cur[0] = 200;
    bus.en = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (bus.spike_frame !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_pre: spike_frame=%b expected 0001", bus.spike_frame);
    end
    bus.en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.idx, bus.spike_out, bus.frame_done, bus.spike_frame} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_async: idx=%0d spike_out=%b frame_done=%b spike_frame=%b expected all 0",
               bus.idx, bus.spike_out, bus.frame_done, bus.spike_frame);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if (bus.frame_done !== (t == 3) || (t == 3 && bus.spike_frame !== 4'b0000)) begin
        n_fail++;
        $display("FAIL reset_first_frame t=%0d: frame_done=%b spike_frame=%b expected %b/0000",
                 t + 1, bus.frame_done, bus.spike_frame, (t == 3));
      end
    end
  endtask

  task automatic test_no_leak();
    logic [N-1:0] exp [10];
    exp = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
            4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    do_reset();
    write_cfg(3'd1, 8'd0);
    cur[0] = 40;
    bus.en = 1'b1;
    for (int sw = 0; sw < 10; sw++) begin
      repeat (N) tick();
      n_checks++;
      if (bus.frame_done !== 1'b1 || bus.spike_frame !== exp[sw]) begin
        n_fail++;
        $display("FAIL no_leak sweep %0d: frame_done=%b spike_frame=%b expected 1/%b",
                 sw + 1, bus.frame_done, bus.spike_frame, exp[sw]);
      end
    end
  endtask

  task automatic test_leak();
    do_reset();
    cur[0] = 40;
    bus.en = 1'b1;
    for (int sw = 0; sw < 6; sw++) begin
      repeat (N) tick();
      n_checks++;
      if (bus.frame_done !== 1'b1 || bus.spike_frame !== ((sw == 5) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL leak sweep %0d: frame_done=%b spike_frame=%b expected 1/%b",
                 sw + 1, bus.frame_done, bus.spike_frame, (sw == 5) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    write_cfg(3'd0, 8'd255);
    write_cfg(3'd1, 8'd0);
    cur[2] = 200;
    bus.en = 1'b1;
    for (int sw = 0; sw < 2; sw++) begin
      repeat (N) tick();
      n_checks++;
      if (bus.spike_frame !== ((sw == 1) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL saturation sweep %0d: spike_frame=%b expected %b",
                 sw + 1, bus.spike_frame, (sw == 1) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  task automatic test_inhibition();
    do_reset();
    write_cfg(3'd4, 8'd50);
    write_cfg(3'd1, 8'd0);
    cur[0] = 200;
    cur[1] = 100;
    bus.en = 1'b1;
    for (int sw = 0; sw < 2; sw++) begin
      repeat (N) tick();
      n_checks++;
      if (bus.spike_frame !== ((sw == 1) ? 4'b0010 : 4'b0001)) begin
        n_fail++;
        $display("FAIL inhibition sweep %0d: spike_frame=%b expected %b",
                 sw + 1, bus.spike_frame, (sw == 1) ? 4'b0010 : 4'b0001);
      end
    end
  endtask

  task automatic test_stall_race();
    logic [N-1:0] held;
    do_reset();
    cur[0] = 200;
    bus.en = 1'b1;
    tick();
    tick();
    held = bus.spike_out;
    bus.en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_checks++;
      if (bus.idx !== 2'd2 || bus.spike_out !== held || bus.spike_out !== 4'b0001 ||
          bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold t=%0d: idx=%0d spike_out=%b frame_done=%b expected 2/0001/0",
                 t, bus.idx, bus.spike_out, bus.frame_done);
      end
    end
    bus.en = 1'b1;
    tick();
    n_checks++;
    if (bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early_frame: frame_done=%b expected 0", bus.frame_done);
    end
    tick();
    n_checks++;
    if (bus.frame_done !== 1'b1 || bus.spike_frame !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_frame: frame_done=%b spike_frame=%b expected 1/0001",
               bus.frame_done, bus.spike_frame);
    end
    cur[0] = 0; cur[1] = 20; cur[2] = 20;
    tick();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 8'd10;
    tick();
    n_checks++;
    if (bus.spike_out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL race_old_thresh: spike_out[1]=%b expected 0", bus.spike_out[1]);
    end
    tick();
    n_checks++;
    if (bus.spike_out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL race_new_thresh: spike_out[2]=%b expected 1", bus.spike_out[2]);
    end
    tick();
    n_checks++;
    if (bus.frame_done !== 1'b1 || bus.spike_frame !== 4'b0100) begin
      n_fail++;
      $display("FAIL race_frame: frame_done=%b spike_frame=%b expected 1/0100",
               bus.frame_done, bus.spike_frame);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 600; t++) begin
      bus.en = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < N; k++) cur[k] = $urandom_range(0, 120);
      if ($urandom_range(0, 9) == 0) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'($urandom_range(0, 7));
        bus.cfg_data = W'($urandom_range(0, VMAX));
      end
      tick();
      n_checks++;
      if (bus.idx !== 2'(midx) || bus.spike_out !== mspk ||
          bus.frame_done !== mdone || bus.spike_frame !== mframe) begin
        n_fail++;
        $display("FAIL random t=%0d: idx=%0d spike_out=%b frame_done=%b spike_frame=%b expected %0d/%b/%b/%b",
                 t, bus.idx, bus.spike_out, bus.frame_done, bus.spike_frame,
                 midx, mspk, mdone, mframe);
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.cur_in = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    model_reset();
    test_reset();
    test_no_leak();
    test_leak();
    test_saturation();
    test_inhibition();
    test_stall_race();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
